// File: rtl/bmp_stream_parser_if.sv
// rtl/bmp_stream_parser_if.sv - data_io download input and SRAM write-request handshake bundle
interface bmp_stream_parser_if #(
    parameter int ADDR_W = 19
);
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    // parser side: consumes the download, produces write requests
    modport master (
        input  ioctl_download,
        input  ioctl_wr,
        input  ioctl_addr,
        input  ioctl_dout,
        input  wr_ready,
        output wr_valid,
        output wr_addr,
        output wr_data
    );

    // environment side: data_io source and SRAM arbiter sink
    modport slave (
        output ioctl_download,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_dout,
        output wr_ready,
        input  wr_valid,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/bmp_stream_parser.sv
// rtl/bmp_stream_parser.sv - BMP header parser feeding a buffered SRAM byte-write request queue

module bmp_wr_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 8
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             push_ok,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // a full queue still takes a push when the head leaves in the same cycle;
    // the write then lands in the slot being vacated, which is read before the edge
    assign empty   = (count == '0);
    assign push_ok = push & ((count != DEPTH_C) | pop);
    assign head    = mem[rd_ptr];

    // entry storage; contents are only meaningful while counted, so no reset
    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // pointers and occupancy; flush discards everything queued
    always_ff @(posedge clk_sys) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop);
        end
    end
endmodule

module bmp_stream_parser #(
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    bmp_stream_parser_if.master bus,
    output logic [23:0]         data_start,
    output logic [15:0]         img_width,
    output logic [15:0]         img_height,
    output logic                bmp_loaded,
    output logic                bmp_error,
    output logic                overflow
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HEADER = 3'd1;
    localparam logic [2:0] S_PIXELS = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    localparam int QW = ADDR_W + 8;

    logic [2:0]    state;
    logic          wr_last;
    logic          dl_last;
    logic [7:0]    sig0;
    logic [7:0]    sig1;
    logic [15:0]   bpp;

    logic          byte_take;
    logic          dl_rise;
    logic          dl_fall;
    logic [24:0]   ds_ext;
    logic [24:0]   pix_off;
    logic          off_fits;
    logic          hdr_cap;
    logic          hdr_done;
    logic          hdr_ok;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          fifo_empty;
    logic [QW-1:0] push_data;
    logic [QW-1:0] head;

    // one byte per ioctl_wr strobe, however long the strobe is held
    assign byte_take = bus.ioctl_wr & ~wr_last & bus.ioctl_download;
    assign dl_rise   = bus.ioctl_download & ~dl_last;
    assign dl_fall   = ~bus.ioctl_download & dl_last;

    // payload offset relative to the pixel data start, 25-bit unsigned
    assign ds_ext   = {1'b0, data_start};
    assign pix_off  = bus.ioctl_addr - ds_ext;
    assign off_fits = ((pix_off >> ADDR_W) == 25'd0);

    // header fields may also be captured in the cycle the download starts
    assign hdr_cap = byte_take & ((state == S_HEADER) | dl_rise) & (bus.ioctl_addr < 25'd30);

    // the header is judged at the first byte past both the fixed header and data_start
    assign hdr_done = (state == S_HEADER) & ~dl_rise & byte_take
                    & (bus.ioctl_addr >= 25'd30) & (bus.ioctl_addr >= ds_ext);
    assign hdr_ok   = (sig0 == 8'h42) & (sig1 == 8'h4D) & (bpp == 16'd32)
                    & (data_start >= 24'd30);

    // the deciding byte of a good header is already the first payload byte
    assign push_req  = ~dl_rise & byte_take & off_fits
                     & ((state == S_PIXELS) | (hdr_done & hdr_ok));
    assign push_data = {pix_off[ADDR_W-1:0], bus.ioctl_dout};
    assign pop       = ~fifo_empty & bus.wr_ready;

    bmp_wr_fifo #(
        .WIDTH (QW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .flush     (dl_rise),
        .push      (push_req),
        .push_data (push_data),
        .pop       (pop),
        .push_ok   (push_ok),
        .empty     (fifo_empty),
        .head      (head)
    );

    // request outputs read as zero whenever nothing is queued
    assign bus.wr_valid = ~fifo_empty;
    assign bus.wr_addr  = fifo_empty ? '0 : head[QW-1:8];
    assign bus.wr_data  = fifo_empty ? '0 : head[7:0];

    // strobe and download edge history; dl_last comes out of reset high so a
    // download already running across reset is not mistaken for a new one
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wr_last <= 1'b0;
            dl_last <= 1'b1;
        end else begin
            wr_last <= bus.ioctl_wr;
            dl_last <= bus.ioctl_download;
        end
    end

    // load sequencing and sticky status flags
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            bmp_loaded <= 1'b0;
            bmp_error  <= 1'b0;
            overflow   <= 1'b0;
        end else if (dl_rise) begin
            state      <= S_HEADER;
            bmp_loaded <= 1'b0;
            bmp_error  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
            case (state)
                S_HEADER: begin
                    if (dl_fall) begin
                        bmp_error <= 1'b1;
                        state     <= S_ERROR;
                    end else if (hdr_done) begin
                        if (hdr_ok) begin
                            state <= S_PIXELS;
                        end else begin
                            bmp_error <= 1'b1;
                            state     <= S_ERROR;
                        end
                    end
                end
                S_PIXELS: begin
                    if (dl_fall) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
                        bmp_loaded <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // little-endian header field capture, cleared at each download start
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sig0       <= '0;
            sig1       <= '0;
            bpp        <= '0;
            data_start <= '0;
            img_width  <= '0;
            img_height <= '0;
        end else begin
            if (dl_rise) begin
                sig0       <= '0;
                sig1       <= '0;
                bpp        <= '0;
                data_start <= '0;
                img_width  <= '0;
                img_height <= '0;
            end
            if (hdr_cap) begin
                case (bus.ioctl_addr[4:0])
                    5'd0:  sig0              <= bus.ioctl_dout;
                    5'd1:  sig1              <= bus.ioctl_dout;
                    5'd10: data_start[7:0]   <= bus.ioctl_dout;
                    5'd11: data_start[15:8]  <= bus.ioctl_dout;
                    5'd12: data_start[23:16] <= bus.ioctl_dout;
                    5'd18: img_width[7:0]    <= bus.ioctl_dout;
                    5'd19: img_width[15:8]   <= bus.ioctl_dout;
                    5'd22: img_height[7:0]   <= bus.ioctl_dout;
                    5'd23: img_height[15:8]  <= bus.ioctl_dout;
                    5'd28: bpp[7:0]          <= bus.ioctl_dout;
                    5'd29: bpp[15:8]         <= bus.ioctl_dout;
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bmp_stream_parser.sv
// tb/tb_bmp_stream_parser.sv - directed and randomized BMP downloads checked against a file-level model
module tb_bmp_stream_parser;
    localparam int ADDR_W = 19;
    localparam int DEPTH  = 8;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] data_start;
    logic [15:0] img_width;
    logic [15:0] img_height;
    logic        bmp_loaded;
    logic        bmp_error;
    logic        overflow;

    bmp_stream_parser_if #(.ADDR_W(ADDR_W)) bus ();

    bmp_stream_parser #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .bus        (bus),
        .data_start (data_start),
        .img_width  (img_width),
        .img_height (img_height),
        .bmp_loaded (bmp_loaded),
        .bmp_error  (bmp_error),
        .overflow   (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  fbytes [256];
    int          flen;
    logic [26:0] mq [$];
    bit          m_ovf;
    bit          m_active;
    bit          m_hdr_ok;
    bit          m_flush;
    int          m_ds;
    int          ready_mode;
    int          dut_writes;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int file_ds();
        return int'({fbytes[12], fbytes[11], fbytes[10]});
    endfunction

    task automatic build_file(input logic [7:0] s0, input int bpp, input int ds,
                              input int w, input int h, input int npay);
        for (int i = 0; i < 256; i++) fbytes[i] = 8'($urandom);
        fbytes[0]  = s0;
        fbytes[1]  = 8'h4D;
        fbytes[10] = 8'(ds);
        fbytes[11] = 8'(ds >> 8);
        fbytes[12] = 8'(ds >> 16);
        fbytes[18] = 8'(w);
        fbytes[19] = 8'(w >> 8);
        fbytes[22] = 8'(h);
        fbytes[23] = 8'(h >> 8);
        fbytes[28] = 8'(bpp);
        fbytes[29] = 8'(bpp >> 8);
        flen = ((ds > 30) ? ds : 30) + npay;
    endtask

    task automatic tick(input bit take);
        bit rdy;
        logic [ADDR_W-1:0] off;
        check("wr_valid", 32'(bus.wr_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("wr_addr", 32'(bus.wr_addr), 32'(mq[0][26:8]));
            check("wr_data", 32'(bus.wr_data), 32'(mq[0][7:0]));
        end
        if (bmp_loaded) check("loaded_while_queued", 32'(bus.wr_valid), 32'd0);
        case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            2:       rdy = !bus.ioctl_download;
            3:       rdy = !bus.ioctl_download || (mq.size() >= DEPTH);
            default: rdy = 1'b0;
        endcase
        bus.wr_ready = rdy;
        if (rdy && bus.wr_valid) dut_writes++;
        if (rdy && mq.size() != 0) void'(mq.pop_front());
        if (!reset_n) begin
            mq.delete();
            m_ovf    = 1'b0;
            m_active = 1'b0;
        end else if (m_flush) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_flush = 1'b0;
        end else if (take && m_active && m_hdr_ok && int'(bus.ioctl_addr) >= m_ds) begin
            off = ADDR_W'(int'(bus.ioctl_addr) - m_ds);
            if (mq.size() < DEPTH) mq.push_back({off, bus.ioctl_dout});
            else m_ovf = 1'b1;
        end
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic send_byte(input int a, input int hold, input int gap);
        bus.ioctl_addr = 25'(a);
        bus.ioctl_dout = fbytes[a];
        bus.ioctl_wr   = 1'b1;
        for (int i = 0; i < hold; i++) tick(i == 0);
        bus.ioctl_wr = 1'b0;
        for (int i = 0; i < gap; i++) tick(1'b0);
    endtask

    task automatic send_range(input int first, input int last, input int hold, input int gap);
        for (int a = first; a <= last; a++) send_byte(a, hold, gap);
    endtask

    task automatic start_dl();
        m_ds     = file_ds();
        m_hdr_ok = (fbytes[0] == 8'h42) && (fbytes[1] == 8'h4D)
                && ({fbytes[29], fbytes[28]} == 16'd32) && (m_ds >= 30);
        m_active = 1'b1;
        m_flush  = 1'b1;
        bus.ioctl_download = 1'b1;
        tick(1'b0);
    endtask

    task automatic finish_dl();
        bit exp_loaded;
        bit exp_err;
        int lim;
        lim        = (m_ds > 30) ? m_ds : 30;
        exp_loaded = m_active && m_hdr_ok && (flen > lim);
        exp_err    = m_active && !exp_loaded;
        bus.ioctl_download = 1'b0;
        tick(1'b0);
        for (int i = 0; i < 200; i++) begin
            if (mq.size() == 0 && bmp_loaded === exp_loaded && bmp_error === exp_err) break;
            tick(1'b0);
        end
        check("bmp_loaded", 32'(bmp_loaded), 32'(exp_loaded));
        check("bmp_error", 32'(bmp_error), 32'(exp_err));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("queue_drained", 32'(bus.wr_valid), 32'd0);
        check("data_start", 32'(data_start), m_active ? 32'(m_ds) : 32'd0);
        check("img_width", 32'(img_width), m_active ? 32'({fbytes[19], fbytes[18]}) : 32'd0);
        check("img_height", 32'(img_height), m_active ? 32'({fbytes[23], fbytes[22]}) : 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_valid"}, 32'(bus.wr_valid), 32'd0);
        check({tag, "_data_start"}, 32'(data_start), 32'd0);
        check({tag, "_img_width"}, 32'(img_width), 32'd0);
        check({tag, "_img_height"}, 32'(img_height), 32'd0);
        check({tag, "_loaded"}, 32'(bmp_loaded), 32'd0);
        check({tag, "_error"}, 32'(bmp_error), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.wr_ready       = 1'b0;
        ready_mode = 0;
        m_active   = 1'b0;
        m_flush    = 1'b0;
        m_ovf      = 1'b0;
        m_hdr_ok   = 1'b0;
        m_ds       = 0;
        flen       = 0;
        dut_writes = 0;

        reset_n = 1'b0;
        @(negedge clk_sys);
        tick(1'b0);
        tick(1'b0);
        check_all_zero("reset");
        reset_n = 1'b1;
        tick(1'b0);

        // basic valid image, four payload bytes
        build_file(8'h42, 32, 54, 4, 2, 4);
        fbytes[54] = 8'h11; fbytes[55] = 8'h22; fbytes[56] = 8'h33; fbytes[57] = 8'h44;
        ready_mode = 0;
        dut_writes = 0;
        start_dl();
        send_range(0, flen - 1, 1, 1);
        finish_dl();
        check("t1_writes", 32'(dut_writes), 32'd4);
        check("t1_data_start", 32'(data_start), 32'd54);
        check("t1_width", 32'(img_width), 32'd4);
        check("t1_height", 32'(img_height), 32'd2);

        // bad signature
        build_file(8'h41, 32, 54, 4, 2, 4);
        dut_writes = 0;
        start_dl();
        send_range(0, flen - 1, 1, 1);
        check("t2_error_at_54", 32'(bmp_error), 32'd1);
        finish_dl();
        check("t2_writes", 32'(dut_writes), 32'd0);

        // 24 bpp rejected
        build_file(8'h42, 24, 54, 4, 2, 4);
        dut_writes = 0;
        start_dl();
        send_range(0, flen - 1, 1, 1);
        finish_dl();
        check("t3_writes", 32'(dut_writes), 32'd0);

        // stalled arbiter: nine bytes into an eight-entry queue
        build_file(8'h42, 32, 54, 3, 3, 9);
        ready_mode = 2;
        dut_writes = 0;
        start_dl();
        send_range(0, flen - 1, 1, 1);
        check("t4_overflow", 32'(overflow), 32'd1);
        finish_dl();
        check("t4_writes", 32'(dut_writes), 32'd8);

        // long strobes, pushes into a full queue that pops in the same cycle
        build_file(8'h42, 32, 40, 5, 4, 20);
        ready_mode = 3;
        dut_writes = 0;
        start_dl();
        send_range(0, flen - 1, 3, 1);
        finish_dl();
        check("t5_writes", 32'(dut_writes), 32'd20);
        check("t5_overflow", 32'(overflow), 32'd0);

        // new download while three entries are queued
        build_file(8'h42, 32, 54, 9, 9, 3);
        ready_mode = 4;
        start_dl();
        send_range(0, 56, 1, 1);
        bus.ioctl_download = 1'b0;
        tick(1'b0);
        tick(1'b0);
        build_file(8'h42, 32, 40, 7, 5, 6);
        start_dl();
        check_all_zero("restart");
        ready_mode = 0;
        send_range(0, flen - 1, 1, 1);
        finish_dl();

        // reset in the middle of the payload
        build_file(8'h42, 32, 54, 8, 8, 10);
        ready_mode = 4;
        start_dl();
        send_range(0, 56, 1, 1);
        reset_n = 1'b0;
        tick(1'b0);
        reset_n = 1'b1;
        check_all_zero("midreset");
        ready_mode = 0;
        dut_writes = 0;
        send_range(57, flen - 1, 1, 1);
        finish_dl();
        check("t7_writes", 32'(dut_writes), 32'd0);

        // randomized files, strobe shapes and arbiter behaviour
        for (int t = 0; t < 10; t++) begin
            int ds;
            int npay;
            int hold;
            int gap;
            int bpp;
            logic [7:0] s0;
            ds   = $urandom_range(26, 60);
            npay = $urandom_range(0, 24);
            s0   = ($urandom_range(0, 4) == 0) ? 8'h41 : 8'h42;
            bpp  = ($urandom_range(0, 4) == 0) ? 24 : 32;
            hold = $urandom_range(1, 3);
            gap  = $urandom_range(1, 2);
            ready_mode = $urandom_range(0, 3);
            build_file(s0, bpp, ds, $urandom_range(1, 640), $urandom_range(1, 480), npay);
            start_dl();
            send_range(0, flen - 1, hold, gap);
            finish_dl();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
